// File: rtl/dmem_responder.sv
// dmem_responder: MEM-stage data-memory responder with a fixed multi-cycle latency.
// A load/store request arriving from EX/MEM is latched in IDLE and held in WAIT
// for the configured latency. Results are then presented in the DONE cycle.
// Ports:
//   clk_i, rst_i              clock, synchronous active-low reset
//   memread_i, memwrite_i     load / store request strobes
//   addr_i, wdata_i           byte address and store data
//   rdata_o, err_o            registered load data and access error, valid in DONE
//   stall_o                   combinational; high while a request is outstanding
module dmem_responder #(
  parameter int unsigned DEPTH   = 32,
  parameter int unsigned LATENCY = 2
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        memread_i,
  input  logic        memwrite_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  output logic [31:0] rdata_o,
  output logic        stall_o,
  output logic        err_o
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = 4;
  localparam logic [CW-1:0] CNT_INIT = CW'((LATENCY >= 2) ? LATENCY - 2 : 0);
  localparam logic [29:0]   DEPTH_W  = 30'(DEPTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t          state;
  logic [CW-1:0]   cnt;
  logic            rd_q;
  logic            wr_q;
  logic [31:0]     addr_q;
  logic [31:0]     wdata_q;
  logic [31:0]     mem [DEPTH];

  logic            req;
  logic            src_rd;
  logic            src_wr;
  logic [31:0]     src_addr;
  logic            done_err;
  logic [31:0]     done_rdata;
  logic            commit;

  // Misaligned, out of range, or simultaneous read+write (treated as a faulting write).
  function automatic logic acc_err(input logic rd, input logic wr, input logic [31:0] a);
    return (a[1:0] != 2'b00) || (a[31:2] >= DEPTH_W) || (rd && wr);
  endfunction

  assign req = memread_i | memwrite_i;

  // Stall covers the request cycle in IDLE plus all of WAIT; reset forces it low.
  assign stall_o = rst_i && (((state == IDLE) && req) || (state == WAIT));

  // The access completing on entry to DONE comes straight from the inputs only when
  // a single-cycle latency jumps IDLE -> DONE; otherwise it comes from the latched copy.
  always_comb begin
    src_rd   = rd_q;
    src_wr   = wr_q;
    src_addr = addr_q;
    if (state == IDLE) begin
      src_rd   = memread_i;
      src_wr   = memwrite_i;
      src_addr = addr_i;
    end
  end

  always_comb begin
    done_err   = acc_err(src_rd, src_wr, src_addr);
    done_rdata = '0;
    if (src_rd && !src_wr && !done_err) begin
      done_rdata = mem[src_addr[AW+1:2]];
    end
  end

  // Request sequencing, latching and result registers.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state   <= IDLE;
      cnt     <= '0;
      rdata_o <= '0;
      err_o   <= 1'b0;
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req) begin
            rd_q    <= memread_i;
            wr_q    <= memwrite_i;
            addr_q  <= addr_i;
            wdata_q <= wdata_i;
            if (LATENCY == 1) begin
              state   <= DONE;
              rdata_o <= done_rdata;
              err_o   <= done_err;
            end else begin
              state <= WAIT;
              cnt   <= CNT_INIT;
            end
          end
        end
        WAIT: begin
          if (cnt == '0) begin
            state   <= DONE;
            rdata_o <= done_rdata;
            err_o   <= done_err;
          end else begin
            cnt <= cnt - CW'(1);
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // Stores commit on the edge leaving DONE; a reset at that edge cancels them.
  assign commit = rst_i && (state == DONE) && wr_q && !acc_err(rd_q, wr_q, addr_q);

  // Storage array is deliberately not reset.
  always_ff @(posedge clk_i) begin
    if (commit) begin
      mem[addr_q[AW+1:2]] <= wdata_q;
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Testbench for dmem_responder: three instances (LATENCY 2, 1, 15) exercised one after
// another with directed and random load/store traffic. Expected results come from a
// word-array model and are queued at issue; a negedge monitor pops them at each DONE.
module tb_dmem_responder;

  localparam int N     = 3;
  localparam int DEPTH = 32;

  function automatic int lat_of(input int i);
    return (i == 0) ? 2 : ((i == 1) ? 1 : 15);
  endfunction

  typedef struct {
    int          inst;
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst      [N];
  logic        memread  [N];
  logic        memwrite [N];
  logic [31:0] addr     [N];
  logic [31:0] wdata    [N];
  logic [31:0] rdata    [N];
  logic        stall    [N];
  logic        err      [N];

  for (genvar g = 0; g < N; g++) begin : g_dut
    dmem_responder #(.DEPTH(DEPTH), .LATENCY(lat_of(g))) u_dut (
      .clk_i      (clk),
      .rst_i      (rst[g]),
      .memread_i  (memread[g]),
      .memwrite_i (memwrite[g]),
      .addr_i     (addr[g]),
      .wdata_i    (wdata[g]),
      .rdata_o    (rdata[g]),
      .stall_o    (stall[g]),
      .err_o      (err[g])
    );
  end

  int          vecs = 0;
  int          bad  = 0;
  exp_t        q[$];
  logic [31:0] mdl [DEPTH];
  int          run  [N];
  bit          prev [N];

  task automatic chk(input string name, input int i, input logic [31:0] act, input logic [31:0] exp);
    vecs++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s (lat=%0d): got 0x%08h expected 0x%08h", name, lat_of(i), act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear(input int i);
    memread[i]  = 1'b0;
    memwrite[i] = 1'b0;
    addr[i]     = '0;
    wdata[i]    = '0;
  endtask

  // Queue the expected outcome, then present the request for the full access window.
  task automatic issue(input int i, input bit rd, input bit wr, input logic [31:0] a,
                       input logic [31:0] d);
    exp_t e;
    bit   e_err;
    e_err   = (a[1:0] != 2'b00) || (a[31:2] >= 30'(DEPTH)) || (rd && wr);
    e.inst  = i;
    e.err   = e_err;
    e.rdata = (rd && !wr && !e_err) ? mdl[a[6:2]] : 32'h0;
    if (wr && !e_err) mdl[a[6:2]] = d;
    q.push_back(e);
    memread[i]  = rd;
    memwrite[i] = wr;
    addr[i]     = a;
    wdata[i]    = d;
    tick();
    if ($urandom_range(0, 3) == 0) clear(i);
    repeat (lat_of(i)) tick();
    clear(i);
    repeat ($urandom_range(0, 2)) tick();
  endtask

  // Store aborted by a reset pulse one cycle after it is accepted.
  task automatic abort_store(input int i, input logic [31:0] a, input logic [31:0] d);
    memwrite[i] = 1'b1;
    addr[i]     = a;
    wdata[i]    = d;
    tick();
    rst[i] = 1'b0;
    clear(i);
    tick();
    rst[i] = 1'b1;
    chk("post_abort_stall", i, 32'(stall[i]), 32'h0);
    chk("post_abort_rdata", i, rdata[i], 32'h0);
    chk("post_abort_err", i, 32'(err[i]), 32'h0);
    tick();
  endtask

  task automatic run_inst(input int i);
    logic [31:0] a;
    logic [31:0] last_a;
    int          op;
    int          kind;
    for (int w = 0; w < DEPTH; w++) issue(i, 1'b0, 1'b1, 32'(w * 4), $urandom);
    issue(i, 1'b0, 1'b1, 32'h8, 32'hDEADBEEF);
    issue(i, 1'b1, 1'b0, 32'h8, 32'h0);
    issue(i, 1'b1, 1'b0, 32'h6, 32'h0);
    issue(i, 1'b0, 1'b1, 32'h80, 32'h1234);
    issue(i, 1'b1, 1'b0, 32'h7C, 32'h0);
    issue(i, 1'b1, 1'b1, 32'h4, 32'hFFFFFFFF);
    issue(i, 1'b1, 1'b0, 32'h4, 32'h0);
    abort_store(i, 32'hC, 32'h55);
    issue(i, 1'b1, 1'b0, 32'hC, 32'h0);
    last_a = 32'h0;
    for (int k = 0; k < 30; k++) begin
      op   = $urandom_range(0, 7);
      kind = $urandom_range(0, 11);
      if (kind < 7)       a = 32'($urandom_range(0, DEPTH - 1)) << 2;
      else if (kind < 8)  a = (32'($urandom_range(0, DEPTH - 1)) << 2) + 32'($urandom_range(1, 3));
      else if (kind < 9)  a = 32'($urandom_range(DEPTH, 2 * DEPTH)) << 2;
      else if (kind < 10) a = $urandom;
      else                a = last_a;
      last_a = a;
      issue(i, (op < 4) || (op == 7), op >= 4, a, $urandom);
    end
    repeat (lat_of(i) + 3) tick();
    chk("queue_drained", i, 32'(q.size()), 32'h0);
  endtask

  // Monitor: a falling stall edge marks DONE; compare results and stall length.
  initial begin
    exp_t e;
    for (int i = 0; i < N; i++) begin
      run[i]  = 0;
      prev[i] = 1'b0;
    end
    forever begin
      @(negedge clk);
      for (int i = 0; i < N; i++) begin
        if (rst[i] !== 1'b1) begin
          run[i]  = 0;
          prev[i] = 1'b0;
        end else begin
          if (stall[i] === 1'b1) begin
            run[i]++;
            if (run[i] == 20) chk("stall_timeout", i, 32'(run[i]), 32'(lat_of(i)));
          end else if (prev[i]) begin
            if (q.size() == 0) begin
              chk("done_without_request", i, 32'(q.size()), 32'h1);
            end else begin
              e = q.pop_front();
              chk("done_instance", i, 32'(i), 32'(e.inst));
              chk("stall_len", i, 32'(run[i]), 32'(lat_of(i)));
              chk("rdata", i, rdata[i], e.rdata);
              chk("err", i, 32'(err[i]), 32'(e.err));
            end
            run[i] = 0;
          end
          prev[i] = (stall[i] === 1'b1);
        end
      end
    end
  end

  initial begin
    for (int i = 0; i < N; i++) begin
      rst[i] = 1'b0;
      clear(i);
    end
    tick();
    tick();
    for (int i = 0; i < N; i++) begin
      chk("reset_stall", i, 32'(stall[i]), 32'h0);
      chk("reset_rdata", i, rdata[i], 32'h0);
      chk("reset_err", i, 32'(err[i]), 32'h0);
    end
    for (int i = 0; i < N; i++) rst[i] = 1'b1;
    tick();
    for (int i = 0; i < N; i++) run_inst(i);
    $display("== %0d vectors applied, %0d miscompares ==", vecs, bad);
    $finish;
  end

endmodule
